// File: rtl/slot_pool_arbiter.sv
// Round-robin allocator handing out slots from a shared free bitmap.
// Grants are combinational from the registered bitmap; protocol errors are sticky.
module slot_pool_arbiter #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned NumSlots = 8,
    localparam int unsigned SlotIdxWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1,
    localparam int unsigned CountWidth   = $clog2(NumSlots + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic [SlotIdxWidth-1:0] grant_slot_o,
    input  logic                    free_valid_i,
    input  logic [SlotIdxWidth-1:0] free_slot_i,
    output logic [CountWidth-1:0]   free_cnt_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    err_o
);

    localparam int unsigned PtrWidth = $clog2(NumReq);

    logic [NumSlots-1:0]     free_map;
    logic [NumSlots-1:0]     free_map_next;
    logic [PtrWidth-1:0]     rr_ptr;
    logic                    err;
    logic                    err_next;
    logic                    req_found;
    logic                    grant_en;
    logic [PtrWidth-1:0]     grant_idx;
    logic [SlotIdxWidth-1:0] low_slot;
    logic [CountWidth-1:0]   free_cnt;
    logic                    free_in_range;

    // Round-robin search starting at rr_ptr, wrapping past NumReq-1.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        req_found = 1'b0;
        grant_idx = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            idx = 32'(rr_ptr) + off;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!req_found && req_valid_i[idx]) begin
                req_found = 1'b1;
                grant_idx = PtrWidth'(idx);
            end
        end
    end

    always_comb begin
        low_slot = '0;
        for (int unsigned i = NumSlots; i > 0; i--) begin
            if (free_map[i-1]) begin
                low_slot = SlotIdxWidth'(i - 1);
            end
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int unsigned i = 0; i < NumSlots; i++) begin
            free_cnt = free_cnt + CountWidth'(free_map[i]);
        end
    end

    assign grant_en = req_found && (|free_map);

    always_comb begin
        req_ready_o  = '0;
        grant_slot_o = '0;
        if (grant_en) begin
            req_ready_o[grant_idx] = 1'b1;
            grant_slot_o           = low_slot;
        end
    end

    assign free_cnt_o = free_cnt;
    assign empty_o    = (free_cnt == '0);
    assign full_o     = (free_cnt == CountWidth'(NumSlots));
    assign err_o      = err;

    // A free only sets a bit that was clear in the registered map, so a double
    // free of the slot being granted this cycle still lets the grant clear it.
    always_comb begin
        free_in_range = (32'(free_slot_i) < NumSlots);
        free_map_next = free_map;
        err_next      = err;
        if (grant_en) begin
            free_map_next[low_slot] = 1'b0;
        end
        if (free_valid_i) begin
            if (!free_in_range) begin
                err_next = 1'b1;
            end else if (free_map[free_slot_i]) begin
                err_next = 1'b1;
            end else begin
                free_map_next[free_slot_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            free_map <= '1;
            rr_ptr   <= '0;
            err      <= 1'b0;
        end else begin
            free_map <= free_map_next;
            err      <= err_next;
            if (grant_en) begin
                rr_ptr <= (grant_idx == PtrWidth'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_slot_pool_arbiter.sv
// Directed checks of slot_pool_arbiter: default 4x8 instance plus a 6-slot
// instance for out-of-range frees.
module tb_slot_pool_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [2:0] grant_slot;
    logic       free_valid;
    logic [2:0] free_slot;
    logic [3:0] free_cnt;
    logic       empty;
    logic       full;
    logic       err;

    logic [3:0] req_valid6;
    logic [3:0] req_ready6;
    logic [2:0] grant_slot6;
    logic       free_valid6;
    logic [2:0] free_slot6;
    logic [2:0] free_cnt6;
    logic       empty6;
    logic       full6;
    logic       err6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    slot_pool_arbiter #(.NumReq(4), .NumSlots(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .grant_slot_o (grant_slot),
        .free_valid_i (free_valid),
        .free_slot_i  (free_slot),
        .free_cnt_o   (free_cnt),
        .empty_o      (empty),
        .full_o       (full),
        .err_o        (err)
    );

    slot_pool_arbiter #(.NumReq(4), .NumSlots(6)) dut6 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid6),
        .req_ready_o  (req_ready6),
        .grant_slot_o (grant_slot6),
        .free_valid_i (free_valid6),
        .free_slot_i  (free_slot6),
        .free_cnt_o   (free_cnt6),
        .empty_o      (empty6),
        .full_o       (full6),
        .err_o        (err6)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs
    // sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; free_valid = 1'b0; free_slot = '0;
        req_valid6 = '0; free_valid6 = 1'b0; free_slot6 = '0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_free_cnt", free_cnt, 8);
        check("rst_full", full, 1);
        check("rst_empty", empty, 0);
        check("rst_ready", req_ready, 0);
        check("rst_slot", grant_slot, 0);
        check("rst_err", err, 0);
        check("rst6_free_cnt", free_cnt6, 6);
        check("rst6_full", full6, 1);
        tick();

        // Fill the pool with all requesters active: rotating grants, slots 0..7.
        req_valid = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            settle();
            if (i == 1) begin
                check("fill_cnt_after_first", free_cnt, 7);
                check("fill_full_after_first", full, 0);
            end
            if (i < 8) begin
                check($sformatf("fill_ready_%0d", i), req_ready, 32'(1) << (i % 4));
                check($sformatf("fill_slot_%0d", i), grant_slot, i);
            end else begin
                check("fill_empty", empty, 1);
                check("fill_ready_when_empty", req_ready, 0);
                check("fill_slot_when_empty", grant_slot, 0);
                check("fill_cnt_empty", free_cnt, 0);
            end
            tick();
        end

        // Returned slot is not bypassed to a same-cycle request.
        req_valid = 4'b0100; free_valid = 1'b1; free_slot = 3'd5;
        settle();
        check("nobypass_ready", req_ready, 0);
        tick();
        free_valid = 1'b0;
        settle();
        check("after_free_ready", req_ready, 4'b0100);
        check("after_free_slot", grant_slot, 5);
        check("after_free_cnt", free_cnt, 1);
        tick();
        req_valid = '0;
        settle();
        check("regrant_cnt", free_cnt, 0);
        check("regrant_err", err, 0);

        // Legit free of slot 3, then double free of it.
        free_valid = 1'b1; free_slot = 3'd3;
        tick();
        settle();
        check("free3_cnt", free_cnt, 1);
        check("free3_err", err, 0);
        tick();
        free_valid = 1'b0;
        settle();
        check("dbl_cnt", free_cnt, 1);
        check("dbl_err", err, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("dbl_err_hold_%0d", i), err, 1);
        end
        check("dbl_cnt_hold", free_cnt, 1);

        // Out-of-range free on the 6-slot instance.
        free_valid6 = 1'b1; free_slot6 = 3'd7;
        tick();
        free_valid6 = 1'b0;
        settle();
        check("oor6_err", err6, 1);
        check("oor6_cnt", free_cnt6, 6);

        // Reset with concurrent grant and free, then double free of a slot being granted.
        rst = 1'b1; req_valid = 4'b1111; free_valid = 1'b1; free_slot = 3'd3;
        tick();
        rst = 1'b0; req_valid = '0; free_valid = 1'b0;
        settle();
        check("rst2_cnt", free_cnt, 8);
        check("rst2_err", err, 0);
        check("rst2_err6", err6, 0);
        req_valid = 4'b0001; free_valid = 1'b1; free_slot = 3'd0;
        settle();
        check("dblgrant_ready", req_ready, 4'b0001);
        check("dblgrant_slot", grant_slot, 0);
        tick();
        free_valid = 1'b0; req_valid = '0;
        settle();
        check("dblgrant_cnt", free_cnt, 7);
        check("dblgrant_err", err, 1);

        // Grant of slot 1 and return of slot 0 in the same cycle.
        req_valid = 4'b0011; free_valid = 1'b1; free_slot = 3'd0;
        settle();
        check("gf_ready", req_ready, 4'b0010);
        check("gf_slot", grant_slot, 1);
        tick();
        free_valid = 1'b0; req_valid = 4'b1111;
        settle();
        check("gf_cnt", free_cnt, 7);
        check("gf_next_slot", grant_slot, 0);
        check("gf_next_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;

        // Three grants, then reset discards them.
        rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 4'b1111;
        tick();
        tick();
        tick();
        req_valid = '0;
        settle();
        check("three_cnt", free_cnt, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rst3_cnt", free_cnt, 8);
        check("rst3_err", err, 0);
        check("rst3_full", full, 1);
        req_valid = 4'b1111;
        settle();
        check("rst3_ready", req_ready, 4'b0001);
        check("rst3_slot", grant_slot, 0);
        tick();
        req_valid = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_pool_arbiter.md
SLOT_POOL_ARBITER -- requirements
Module: slot_pool_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters sharing the slot pool (2..16).
REQ-002 SHALL have parameter NumSlots, default 8: number of pool slots (1..64, power of two not required).
REQ-003 SHALL derive localparam SlotIdxWidth = max(1, $clog2(NumSlots)) and localparam CountWidth = $clog2(NumSlots+1).
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i  input  NumReq  per-requester allocation request.
REQ-007 SHALL have port req_ready_o  output  NumReq  one-hot grant; bit i high means requester i is allocated a slot this cycle.
REQ-008 SHALL have port grant_slot_o  output  SlotIdxWidth  slot index given to the granted requester; valid only while req_ready_o is nonzero.
REQ-009 SHALL have port free_valid_i  input  1  slot return strobe.
REQ-010 SHALL have port free_slot_i  input  SlotIdxWidth  index of the returned slot.
REQ-011 SHALL have port free_cnt_o  output  CountWidth  number of free slots (popcount of the free bitmap).
REQ-012 SHALL have port empty_o  output  1  high when free_cnt_o == 0.
REQ-013 SHALL have port full_o  output  1  high when free_cnt_o == NumSlots.
REQ-014 SHALL have port err_o  output  1  sticky protocol-error flag.

Function
REQ-015 SHALL hold a NumSlots-bit registered free bitmap (1 = free), a round-robin pointer rr_ptr (0..NumReq-1), and a sticky error register.
REQ-016 SHALL grant at most one requester per cycle, and only when the registered bitmap is nonzero and req_valid_i is nonzero.
REQ-017 SHALL select the first requester with req_valid_i set, searching upward from rr_ptr with wrap-around from NumReq-1 to 0.
REQ-018 SHALL drive req_ready_o and grant_slot_o combinationally in the same cycle as the request: zero-cycle grant latency.
REQ-019 SHALL set grant_slot_o to the lowest-index set bit of the registered bitmap.
REQ-020 SHALL hold grant_slot_o at 0 when there is no grant.
REQ-021 SHALL, on a grant to requester g, clear the granted slot bit at the next edge and set rr_ptr to (g+1) mod NumReq.
REQ-022 SHALL leave rr_ptr unchanged in any cycle without a grant.
REQ-023 SHALL, on free_valid_i with an in-range index of a slot that is currently allocated, set that bitmap bit at the next edge.
REQ-024 SHALL NOT bypass a returned slot: it becomes grantable one cycle after free_valid_i, never in the same cycle.
REQ-025 SHALL process a grant and a free of a different slot in the same cycle, both taking effect at the same edge.
REQ-026 SHALL treat a free of a slot whose bit is already set (double free) as an error: bitmap bit unchanged, err_o set.
REQ-027 SHALL treat a free with free_slot_i >= NumSlots as an error: bitmap unchanged, err_o set.
REQ-028 SHALL, for a double free of the same slot that is being granted in that cycle, perform the grant (bit cleared) and set err_o.
REQ-029 SHALL hold err_o high once set until rst_i.
REQ-030 SHALL derive free_cnt_o, empty_o and full_o combinationally from the registered bitmap, so they reflect the state after the last edge.
REQ-031 SHALL ignore req_valid_i bits while empty_o is high: req_ready_o stays 0 and rr_ptr is unchanged.

Reset
REQ-032 SHALL, on rst_i high at a rising edge, set the bitmap to all ones, rr_ptr to 0 and err_o to 0.
REQ-033 SHALL therefore present after reset free_cnt_o = NumSlots, full_o = 1, empty_o = 0, req_ready_o = 0 absent requests, grant_slot_o = 0.
REQ-034 SHALL let rst_i override any concurrent grant or free in the same cycle, and SHALL discard all outstanding allocations when reset is asserted mid-operation.

Verification (NumReq=4, NumSlots=8 unless stated)
REQ-035 SHALL check: after reset, req_valid_i=4'b1111 for 1 cycle -> req_ready_o=4'b0001, grant_slot_o=0 that cycle; next cycle free_cnt_o=7, full_o=0.
REQ-036 SHALL check: req_valid_i=4'b1111 held 9 cycles from reset -> grants 0001,0010,0100,1000,0001,0010,0100,1000 with slots 0..7; then empty_o=1 and req_ready_o=0 in cycle 9.
REQ-037 SHALL check: pool empty, free_valid_i=1, free_slot_i=5 and req_valid_i=4'b0100 in the same cycle -> no grant that cycle; next cycle req_ready_o=4'b0100, grant_slot_o=5; following cycle free_cnt_o=0.
REQ-038 SHALL check: slot 3 free, free_valid_i with free_slot_i=3 -> bitmap and free_cnt_o unchanged, err_o=1 from the next cycle and held through 10 idle cycles.
REQ-039 SHALL check: NumSlots=6, free_slot_i=7 -> err_o=1, free_cnt_o unchanged.
REQ-040 SHALL check: after 3 grants, rst_i for 1 cycle -> next cycle free_cnt_o=8, err_o=0; req_valid_i=4'b1111 -> req_ready_o=4'b0001, grant_slot_o=0.
